// File: rtl/mult_accum_pkg.sv
// Shared definitions for the multiply-accumulate block.
//   ACC_W  : accumulator / result width
//   CNT_W  : term count and term counter width
//   PROD_W : width of the unsigned product from the 4x4 multiplier
//   state_t: controller states (IDLE=0, ACCUM=1, DONE=2)
package mult_accum_pkg;

    localparam int ACC_W  = 12;
    localparam int CNT_W  = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mult_accum_if.sv
// Handshake bundle between the multiply-accumulate block and its parent.
//   start/n_terms         : run request and number of products to sum
//   prod/prod_valid/ready : product stream from the multiplier stage
//   acc_out/out_valid/ready: completed result handshake
//   busy                  : block is not idle
// master = parent side, slave = mult_accum side.
interface mult_accum_if #(
    parameter int ACC_W = mult_accum_pkg::ACC_W,
    parameter int CNT_W = mult_accum_pkg::CNT_W
);
    import mult_accum_pkg::*;

    logic              start;
    logic [CNT_W-1:0]  n_terms;
    logic [PROD_W-1:0] prod;
    logic              prod_valid;
    logic              prod_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    modport master (
        output start, n_terms, prod, prod_valid, out_ready,
        input  prod_ready, acc_out, out_valid, busy
    );

    modport slave (
        input  start, n_terms, prod, prod_valid, out_ready,
        output prod_ready, acc_out, out_valid, busy
    );

endinterface

// File: rtl/mult_accum.sv
// Sums n_terms unsigned 8-bit products into an ACC_W-bit accumulator.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mult_accum_if slave (start/n_terms, prod stream, result handshake, busy)
// A run is started from IDLE, accepts products in ACCUM, and holds the
// result in DONE until out_ready. All outputs decode registered state only.
module mult_accum #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mult_accum_if.slave  bus
);
    import mult_accum_pkg::*;

    state_t            state;
    state_t            state_nxt;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  n_lat;
    logic [CNT_W-1:0]  last_idx;
    logic              xfer;

    // Modulo-2^ACC_W add of a zero-extended product.
    function automatic logic [ACC_W-1:0] acc_add(
        input logic [ACC_W-1:0]  a,
        input logic [PROD_W-1:0] p
    );
        return a + {{(ACC_W-PROD_W){1'b0}}, p};
    endfunction

    assign last_idx = n_lat - CNT_W'(1);
    assign xfer     = (state == ACCUM) && bus.prod_valid;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_nxt = (bus.n_terms == '0) ? DONE : ACCUM;
            end
            ACCUM: begin
                if (bus.prod_valid && (cnt == last_idx))
                    state_nxt = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            n_lat <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && bus.start) begin
                acc   <= '0;
                cnt   <= '0;
                n_lat <= bus.n_terms;
            end else if (xfer) begin
                acc <= acc_add(acc, bus.prod);
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.prod_ready = (state == ACCUM);
    assign bus.out_valid  = (state == DONE);
    assign bus.busy       = (state != IDLE);
    assign bus.acc_out    = acc;

endmodule

// File: doc/mult_accum.md
MULT_ACCUM -- requirements
Module: mult_accum

Interface
REQ-001 Parameter ACC_W, default 12, accumulator and result width in bits.
REQ-002 Parameter CNT_W, default 4, width of the term count and the term counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle request to begin a new accumulation run.
REQ-006 n_terms  input  CNT_W  number of products to sum; sampled only when start is accepted.
REQ-007 prod  input  8  unsigned 8-bit product from the 4x4 multiplier stage.
REQ-008 prod_valid  input  1  prod is valid this cycle.
REQ-009 prod_ready  output  1  block accepts prod this cycle.
REQ-010 acc_out  output  ACC_W  accumulated sum of the run.
REQ-011 out_valid  output  1  acc_out holds a completed result.
REQ-012 out_ready  input  1  downstream accepts acc_out this cycle.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ACCUM and DONE.
REQ-015 IDLE: prod_ready=0 and out_valid=0; start=1 SHALL clear acc and the counter, latch n_terms, and go to ACCUM, or to DONE if n_terms=0.
REQ-016 ACCUM: prod_ready SHALL be 1; a transfer occurs when prod_valid and prod_ready are both 1.
REQ-017 On each transfer, acc SHALL become acc + zero-extended prod and the counter SHALL increment by 1.
REQ-018 A transfer with counter = latched n_terms-1 SHALL move the FSM to DONE, so out_valid rises the cycle after the last accepted product (latency 1).
REQ-019 In ACCUM with prod_valid=0, acc and the counter SHALL hold; there is no timeout.
REQ-020 DONE: out_valid=1, prod_ready=0, acc_out stable; out_ready=1 SHALL return the FSM to IDLE next cycle while acc_out keeps its value.
REQ-021 start SHALL be ignored in ACCUM and DONE; changes to n_terms outside IDLE have no effect.
REQ-022 Addition SHALL be unsigned modulo 2^ACC_W; with the defaults the maximum sum 15*225=3375 fits, so no overflow flag exists.
REQ-023 acc_out SHALL be driven directly from the acc register, with no combinational path from any input.
REQ-024 A new run SHALL require at least one IDLE cycle; no back-to-back start from DONE.

Reset
REQ-025 rst_n=0 SHALL force, asynchronously, state=IDLE, acc=0, counter=0, latched n_terms=0, out_valid=0, prod_ready=0, busy=0.
REQ-026 Reset asserted mid-run SHALL abandon the run; no partial result is presented after reset releases.
REQ-027 The first cycle after rst_n rises SHALL be IDLE and SHALL accept start.

Structure
REQ-028 A shared package SHALL hold ACC_W, CNT_W, the product width (8) and the state enumeration with IDLE=0, ACCUM=1, DONE=2.
REQ-029 The block SHALL be a single module with no sub-module; the adder and FSM are inline.
REQ-030 The block SHALL consume the multiplier output unchanged; the multiplier is instantiated by the parent, not inside this block.

Verification
REQ-031 Reset, start, n_terms=3, then prod 10, 20, 30 on consecutive cycles with prod_valid=1 -> out_valid one cycle after 30, acc_out=60, busy=1 until out_ready.
REQ-032 n_terms=15 with prod=225 every cycle -> acc_out=3375 (0xD2F), no wrap.
REQ-033 n_terms=4, prod_valid toggling 1,0,0,1,1,0,1 with values 5,x,x,7,9,x,11 -> only valid beats counted, acc_out=32.
REQ-034 start with n_terms=0 -> DONE next cycle with acc_out=0 and no prod_ready pulse.
REQ-035 start pulsed during ACCUM and DONE, and out_ready held low 5 cycles in DONE -> run unaffected, acc_out stable throughout, IDLE the cycle after out_ready=1.
REQ-036 rst_n pulsed low after 2 of 5 products -> immediate IDLE with acc_out=0; a following run with n_terms=1 and prod=8 gives acc_out=8.
